dmem_responder: RTL

- Memory-side counterpart to the stage-3 memory control outputs.
- Accepts a stage-3 access (`re`, unshifted `w_mask`, `funct3`, address, store data) and aligns the mask and data to the addressed byte lanes.
- Runs a valid/ready request and response exchange with the backing data memory and stalls the pipeline until the access completes.
- Returns the extracted and extended load word to writeback.

---
 rtl/dmem_responder_pkg.sv | 36 +++
 rtl/load_extend.sv | 29 ++
 rtl/dmem_responder.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding,
// default timeout and the RV32 load/store funct3 width/sign codes.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int TIMEOUT_DEFAULT = 255;

    localparam logic [2:0] FNC_LB  = 3'b000;
    localparam logic [2:0] FNC_LH  = 3'b001;
    localparam logic [2:0] FNC_LW  = 3'b010;
    localparam logic [2:0] FNC_LBU = 3'b100;
    localparam logic [2:0] FNC_LHU = 3'b101;
    localparam logic [2:0] FNC_SB  = 3'b000;
    localparam logic [2:0] FNC_SH  = 3'b001;
    localparam logic [2:0] FNC_SW  = 3'b010;

    // Width comes from funct3[1:0] (bit 2 only selects zero-extension for loads).
    // Bytes are always aligned, halfwords need addr[0]=0, words addr[1:0]=0.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] lane);
        logic mis;
        case (funct3 & 3'b011)
            FNC_SB:  mis = 1'b0;
            FNC_SH:  mis = lane[0];
            FNC_SW:  mis = (lane != 2'b00);
            default: mis = (lane != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/halfword lane of a 32-bit read word and
// sign- or zero-extends it according to the load funct3.
module load_extend
    import dmem_responder_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] shifted_s;

    assign shifted_s = rdata >> {lane, 3'b000};

    // Lane select plus sign/zero extension; unknown codes pass the word through.
    always_comb begin
        data = rdata;
        case (funct3)
            FNC_LB:  data = {{24{shifted_s[7]}}, shifted_s[7:0]};
            FNC_LH:  data = {{16{shifted_s[15]}}, shifted_s[15:0]};
            FNC_LW:  data = rdata;
            FNC_LBU: data = {24'h000000, shifted_s[7:0]};
            FNC_LHU: data = {16'h0000, shifted_s[15:0]};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the stage-3 load/store unit. Aligns store mask
// and data to byte lanes, runs a valid/ready request and response exchange
// with the data memory, stalls the pipeline until completion and returns the
// extended load word. Errors (misalign, re+mask conflict, timeout) pulse err.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int AWIDTH  = 32,
    parameter int DWIDTH  = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_valid,
    input  logic [AWIDTH-1:0] addr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic [3:0]        w_mask,
    input  logic              re,
    input  logic [2:0]        funct3,
    output logic              stall,
    output logic [DWIDTH-1:0] load_data,
    output logic              load_valid,
    output logic              err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [AWIDTH-1:0] mem_req_addr,
    output logic              mem_req_we,
    output logic [3:0]        mem_req_wmask,
    output logic [DWIDTH-1:0] mem_req_wdata,
    input  logic              mem_resp_valid,
    input  logic [DWIDTH-1:0] mem_resp_rdata
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    state_t              state_r, state_next_s;
    logic [CNT_W-1:0]    cnt_r, cnt_next_s, cnt_inc_s;
    logic                read_r;
    logic [2:0]          funct3_r;
    logic [1:0]          lane_r;

    logic                access_s, bad_s, latch_s, stall_s;
    logic                err_set_s, ld_ok_s;
    logic [3:0]          wmask_shifted_s;
    logic [DWIDTH-1:0]   wdata_aligned_s;
    logic [DWIDTH-1:0]   ext_s;

    logic                mem_req_valid_r, mem_req_we_r, err_r, load_valid_r;
    logic [AWIDTH-1:0]   mem_req_addr_r;
    logic [3:0]          mem_req_wmask_r;
    logic [DWIDTH-1:0]   mem_req_wdata_r, load_data_r;

    assign access_s        = cpu_valid & (re | (w_mask != 4'b0000));
    assign bad_s           = is_misaligned(funct3, addr[1:0]) | (re & (w_mask != 4'b0000));
    assign wmask_shifted_s = w_mask << addr[1:0];
    assign wdata_aligned_s = wdata << {addr[1:0], 3'b000};
    assign cnt_inc_s       = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};

    load_extend u_load_extend (
        .rdata  (mem_resp_rdata),
        .lane   (lane_r),
        .funct3 (funct3_r),
        .data   (ext_s)
    );

    // Next-state, timeout counter and completion events for the access FSM.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        latch_s      = 1'b0;
        stall_s      = 1'b0;
        err_set_s    = 1'b0;
        ld_ok_s      = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (access_s) begin
                    latch_s = 1'b1;
                    stall_s = 1'b1;
                    if (bad_s) begin
                        state_next_s = S_DONE;
                        err_set_s    = 1'b1;
                    end else begin
                        state_next_s = S_REQ;
                    end
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_REQ: begin
                stall_s = 1'b1;
                if (mem_req_ready) begin
                    if (read_r) begin
                        state_next_s = S_WAIT;
                        cnt_next_s   = '0;
                    end else begin
                        state_next_s = S_DONE;
                    end
                end else begin
                    state_next_s = S_REQ;
                end
            end
            S_WAIT: begin
                stall_s = 1'b1;
                if (mem_resp_valid) begin
                    state_next_s = S_DONE;
                    ld_ok_s      = 1'b1;
                end else if (cnt_inc_s == TIMEOUT_CNT) begin
                    state_next_s = S_DONE;
                    err_set_s    = 1'b1;
                end else begin
                    cnt_next_s = cnt_inc_s;
                end
            end
            S_DONE: begin
                state_next_s = S_IDLE;
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // State and timeout counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Capture the access attributes and the aligned request once per access;
    // they stay frozen through REQ so the memory sees a stable request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read_r          <= 1'b0;
            funct3_r        <= 3'b000;
            lane_r          <= 2'b00;
            mem_req_addr_r  <= '0;
            mem_req_we_r    <= 1'b0;
            mem_req_wmask_r <= 4'b0000;
            mem_req_wdata_r <= '0;
        end else if (latch_s) begin
            read_r          <= re;
            funct3_r        <= funct3;
            lane_r          <= addr[1:0];
            mem_req_addr_r  <= {addr[AWIDTH-1:2], 2'b00};
            mem_req_we_r    <= ~re;
            mem_req_wmask_r <= wmask_shifted_s;
            mem_req_wdata_r <= wdata_aligned_s;
        end
    end

    // Registered handshake/completion outputs; load_data keeps the last good
    // load and is cleared whenever an access ends in error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req_valid_r <= 1'b0;
            err_r           <= 1'b0;
            load_valid_r    <= 1'b0;
            load_data_r     <= '0;
        end else begin
            mem_req_valid_r <= (state_next_s == S_REQ);
            err_r           <= err_set_s;
            load_valid_r    <= ld_ok_s;
            if (ld_ok_s) begin
                load_data_r <= ext_s;
            end else if (err_set_s) begin
                load_data_r <= '0;
            end
        end
    end

    assign stall         = stall_s & ~reset;
    assign load_data     = load_data_r;
    assign load_valid    = load_valid_r;
    assign err           = err_r;
    assign mem_req_valid = mem_req_valid_r;
    assign mem_req_addr  = mem_req_addr_r;
    assign mem_req_we    = mem_req_we_r;
    assign mem_req_wmask = mem_req_wmask_r;
    assign mem_req_wdata = mem_req_wdata_r;

endmodule
